// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU port and the DMA port,
// with CPU priority, bounded DMA starvation and a DMA burst lock.
module dmem_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic [3:0]        cpu_req_we,
    input  logic [31:0]       cpu_req_wdata,
    output logic              cpu_rsp_valid,
    output logic [31:0]       cpu_rsp_rdata,
    input  logic              dma_req_valid,
    output logic              dma_req_ready,
    input  logic [ADDR_W-1:0] dma_req_addr,
    input  logic [3:0]        dma_req_we,
    input  logic [31:0]       dma_req_wdata,
    input  logic              dma_req_last,
    output logic              dma_rsp_valid,
    output logic [31:0]       dma_rsp_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WMAX = CW'(MAX_WAIT);

    typedef enum logic {IDLE, BURST} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          rd_cpu_q, rd_dma_q;
    logic          gnt_cpu, gnt_dma, timeout;

    always_comb begin
        gnt_dma = (state_q == BURST) ? dma_req_valid
                                     : dma_req_valid && (!cpu_req_valid || wait_q == WMAX);
        gnt_cpu = (state_q == IDLE) && cpu_req_valid && !gnt_dma;
        timeout = (state_q == BURST) && !dma_req_valid && (wait_q == WMAX - 1'b1);
        state_d = state_q;
        wait_d  = wait_q;
        if (gnt_dma) begin
            wait_d  = '0;
            state_d = dma_req_last ? IDLE : BURST;
        end else if (dma_req_valid) begin
            wait_d = (wait_q == WMAX) ? wait_q : wait_q + 1'b1;
        end else if (state_q == BURST) begin
            // idle-timeout: the lock is released the cycle the count reaches MAX_WAIT
            wait_d  = timeout ? '0 : wait_q + 1'b1;
            state_d = timeout ? IDLE : BURST;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            wait_q   <= '0;
            rd_cpu_q <= 1'b0;
            rd_dma_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            rd_cpu_q <= gnt_cpu && cpu_req_we == 4'b0000;
            rd_dma_q <= gnt_dma && dma_req_we == 4'b0000;
        end
    end

    assign cpu_req_ready = gnt_cpu;
    assign dma_req_ready = gnt_dma;
    assign mem_en        = gnt_cpu || gnt_dma;
    assign mem_we        = gnt_cpu ? cpu_req_we    : gnt_dma ? dma_req_we    : '0;
    assign mem_addr      = gnt_cpu ? cpu_req_addr  : gnt_dma ? dma_req_addr  : '0;
    assign mem_din       = gnt_cpu ? cpu_req_wdata : gnt_dma ? dma_req_wdata : '0;
    assign cpu_rsp_valid = rd_cpu_q;
    assign dma_rsp_valid = rd_dma_q;
    assign cpu_rsp_rdata = mem_dout;
    assign dma_rsp_rdata = mem_dout;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scenario tasks for dmem_arbiter with a read-response scoreboard
// fed from a behavioural 1-cycle-latency memory.
module tb_dmem_arbiter;
    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_req_valid = 1'b0, cpu_req_ready;
    logic [AW-1:0] cpu_req_addr = '0;
    logic [3:0]    cpu_req_we = '0;
    logic [31:0]   cpu_req_wdata = '0;
    logic          cpu_rsp_valid;
    logic [31:0]   cpu_rsp_rdata;
    logic          dma_req_valid = 1'b0, dma_req_ready;
    logic [AW-1:0] dma_req_addr = '0;
    logic [3:0]    dma_req_we = '0;
    logic [31:0]   dma_req_wdata = '0;
    logic          dma_req_last = 1'b0;
    logic          dma_rsp_valid;
    logic [31:0]   dma_rsp_rdata;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_din;
    logic [31:0]   mem_dout = '0;

    typedef struct {
        logic        port;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sbq[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [31:0] mem [0:1023];
    bit          mem_init = 1'b0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_addr(cpu_req_addr), .cpu_req_we(cpu_req_we), .cpu_req_wdata(cpu_req_wdata),
        .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_rdata(cpu_rsp_rdata),
        .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready),
        .dma_req_addr(dma_req_addr), .dma_req_we(dma_req_we), .dma_req_wdata(dma_req_wdata),
        .dma_req_last(dma_req_last),
        .dma_rsp_valid(dma_rsp_valid), .dma_rsp_rdata(dma_rsp_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // single-port memory with byte enables and one cycle of read latency
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'hC0DE_0000 + i * 7;
            mem_init <= 1'b1;
        end else if (mem_en) begin
            if (mem_we == 4'b0000) mem_dout <= mem[mem_addr[9:0]];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) mem[mem_addr[9:0]][b*8 +: 8] <= mem_din[b*8 +: 8];
        end
    end

    always @(negedge clk) begin
        exp_t e;
        logic hit;
        if (!rst) begin
            hit = sbq.size() > 0 && sbq[0].due <= cyc;
            if (hit || cpu_rsp_valid || dma_rsp_valid) begin
                tests++;
                if (!hit) begin
                    fails++;
                    $display("FAIL rsp cyc=%0d unexpected response cpu_v=%b dma_v=%b", cyc, cpu_rsp_valid, dma_rsp_valid);
                end else begin
                    e = sbq.pop_front();
                    if (cpu_rsp_valid !== !e.port || dma_rsp_valid !== e.port ||
                        (e.port ? dma_rsp_rdata : cpu_rsp_rdata) !== e.data) begin
                        fails++;
                        $display("FAIL rsp cyc=%0d got cpu_v=%b dma_v=%b data=%h want port=%s data=%h",
                                 cyc, cpu_rsp_valid, dma_rsp_valid,
                                 e.port ? dma_rsp_rdata : cpu_rsp_rdata, e.port ? "dma" : "cpu", e.data);
                    end
                end
            end
        end
    end

    task automatic drive(input logic cv, input logic [AW-1:0] ca, input logic [3:0] cwe,
                         input logic [31:0] cwd, input logic dv, input logic [AW-1:0] da,
                         input logic [3:0] dwe, input logic [31:0] dwd, input logic dl,
                         input logic ec, input logic ed, input logic sb);
        cpu_req_valid = cv; cpu_req_addr = ca; cpu_req_we = cwe; cpu_req_wdata = cwd;
        dma_req_valid = dv; dma_req_addr = da; dma_req_we = dwe; dma_req_wdata = dwd;
        dma_req_last  = dl;
        if (sb && ec && cwe == 4'b0000) sbq.push_back('{1'b0, mem[ca[9:0]], cyc + 1});
        if (sb && ed && dwe == 4'b0000) sbq.push_back('{1'b1, mem[da[9:0]], cyc + 1});
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests++;
        if ({cpu_rsp_valid, dma_rsp_valid, mem_en, cpu_req_ready, dma_req_ready} !== 5'b0 || mem_we !== 4'b0) begin
            fails++;
            $display("FAIL reset got rsp=%b%b en=%b rdy=%b%b we=%h want all 0",
                     cpu_rsp_valid, dma_rsp_valid, mem_en, cpu_req_ready, dma_req_ready, mem_we);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_cpu_read();
        drive(1, 14'h10, 4'h0, 0, 0, 0, 4'h0, 0, 0, 1, 0, 1);
        tests++;
        if ({cpu_req_ready, dma_req_ready, mem_en} !== 3'b101 || mem_addr !== 14'h10 || mem_we !== 4'h0) begin
            fails++;
            $display("FAIL cpu_read got rdy=%b%b en=%b addr=%h we=%h want rdy=10 en=1 addr=0010 we=0",
                     cpu_req_ready, dma_req_ready, mem_en, mem_addr, mem_we);
        end
        tick();
        drive(1, 14'h20, 4'hF, 32'hDEAD_BEEF, 0, 0, 4'h0, 0, 0, 1, 0, 1);
        tests++;
        if (mem_we !== 4'hF || mem_din !== 32'hDEAD_BEEF || mem_addr !== 14'h20) begin
            fails++;
            $display("FAIL cpu_write got we=%h din=%h addr=%h want we=f din=deadbeef addr=0020", mem_we, mem_din, mem_addr);
        end
        tick();
        drive(1, 14'h20, 4'b0011, 32'h0000_1234, 0, 0, 4'h0, 0, 0, 1, 0, 1);
        tick();
        drive(1, 14'h20, 4'h0, 0, 0, 0, 4'h0, 0, 0, 1, 0, 1);
        tests++;
        if (mem[32] !== 32'hDEAD_1234) begin
            fails++;
            $display("FAIL cpu_bytes got mem=%h want dead1234", mem[32]);
        end
        tick();
        drive(0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 1);
        tests++;
        if (mem_en !== 1'b0 || mem_we !== 4'h0) begin
            fails++;
            $display("FAIL cpu_idle got en=%b we=%h want 0 0", mem_en, mem_we);
        end
        tick();
    endtask

    task automatic test_fairness();
        for (int k = 0; k < 10; k++) begin
            logic ed, ec;
            ed = (k % 5 == 4);
            ec = !ed;
            drive(1, AW'(k), 4'h0, 0, 1, AW'(16'h100 + k), 4'h0, 0, 1, ec, ed, 1);
            tests++;
            if ({cpu_req_ready, dma_req_ready, mem_en} !== {ec, ed, 1'b1} ||
                mem_addr !== (ec ? AW'(k) : AW'(16'h100 + k))) begin
                fails++;
                $display("FAIL fair k=%0d got rdy=%b%b en=%b addr=%h want rdy=%b%b",
                         k, cpu_req_ready, dma_req_ready, mem_en, mem_addr, ec, ed);
            end
            tick();
        end
    endtask

    task automatic test_burst();
        int beat = 0;
        for (int k = 0; k < 9; k++) begin
            logic ed, ec;
            ed = k >= 4 && k <= 7;
            ec = !ed;
            drive(1, AW'(16'h203 - k % 4), 4'h0, 0, beat < 4, AW'(16'h200 + beat), 4'hF,
                  32'hB000_0000 + beat, beat == 3, ec, ed, 1);
            tests++;
            if ({cpu_req_ready, dma_req_ready} !== {ec, ed} ||
                (ed && (mem_we !== 4'hF || mem_din !== 32'hB000_0000 + beat))) begin
                fails++;
                $display("FAIL burst k=%0d got rdy=%b%b we=%h din=%h want rdy=%b%b",
                         k, cpu_req_ready, dma_req_ready, mem_we, mem_din, ec, ed);
            end
            if (ed) beat++;
            tick();
        end
    endtask

    task automatic test_timeout();
        int beat = 0;
        for (int k = 0; k < 12; k++) begin
            logic ed, ec, dv;
            dv = (k < 2 || k >= 6) && beat < 3;
            ed = k == 0 || k == 1 || k == 10;
            ec = k >= 6 && k != 10;
            drive(k >= 1, AW'(16'h300 + k), 4'h0, 0, dv, AW'(16'h310 + beat), 4'h0, 0,
                  beat == 2, ec, ed, 1);
            tests++;
            if ({cpu_req_ready, dma_req_ready, mem_en} !== {ec, ed, ec | ed}) begin
                fails++;
                $display("FAIL timeout k=%0d got rdy=%b%b en=%b want rdy=%b%b",
                         k, cpu_req_ready, dma_req_ready, mem_en, ec, ed);
            end
            if (ed) beat++;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) begin
            logic ec;
            ec = (k % 2 == 0);
            drive(ec, AW'(16'h40 + k), 4'h0, 0, !ec, AW'(16'h50 + k), 4'h0, 0, 1, ec, !ec, 1);
            tests++;
            if ({cpu_req_ready, dma_req_ready} !== {ec, !ec}) begin
                fails++;
                $display("FAIL b2b k=%0d got rdy=%b%b want rdy=%b%b", k, cpu_req_ready, dma_req_ready, ec, !ec);
            end
            tick();
        end
        drive(0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 1);
        tick();
    endtask

    task automatic test_reset_mid();
        for (int r = 0; r < 2; r++) begin
            if (r == 0) drive(1, 14'h11, 4'h0, 0, 1, 14'h12, 4'h0, 0, 1, 1, 0, 0);
            else        drive(0, 0, 4'h0, 0, 1, 14'h30, 4'hF, 32'h5555_AAAA, 0, 0, 1, 0);
            tests++;
            if ({cpu_req_ready, dma_req_ready} !== {r == 0, r == 1}) begin
                fails++;
                $display("FAIL rstmid r=%0d pre-grant got rdy=%b%b", r, cpu_req_ready, dma_req_ready);
            end
            tick();
            rst = 1'b1;
            drive(0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0);
            tests++;
            if (cpu_rsp_valid !== 1'b0 || dma_rsp_valid !== 1'b0) begin
                fails++;
                $display("FAIL rstmid r=%0d got rsp=%b%b want 00", r, cpu_rsp_valid, dma_rsp_valid);
            end
            @(posedge clk);
            #1 rst = 1'b0;
            for (int k = 0; k < 5; k++) begin
                logic ed;
                ed = k == 4;
                drive(1, AW'(16'h60 + k), 4'h0, 0, 1, AW'(16'h70 + k), 4'h0, 0, 1, !ed, ed, 1);
                tests++;
                if ({cpu_req_ready, dma_req_ready} !== {!ed, ed}) begin
                    fails++;
                    $display("FAIL rstmid r=%0d k=%0d got rdy=%b%b want rdy=%b%b",
                             r, k, cpu_req_ready, dma_req_ready, !ed, ed);
                end
                tick();
            end
        end
        drive(0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 1);
        tick();
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_fairness();
        test_burst();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        repeat (2) tick();
        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d pending responses want 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
